// File: rtl/alu_shift_seq.sv
// alu_shift_seq -- sequential shifter that performs one single-bit shift per
// clock cycle, so a shift by SHAMT takes SHAMT cycles in the SHIFT state.
//
// Operation: a start accepted in IDLE captures A, SHAMT and MODE. SHIFT
// applies one shift step per cycle until the down-counter reaches zero. DONE
// then copies the working register into Z. done pulses for one cycle together
// with the new Z value, SHAMT+2 cycles after the accepting edge.
//
// Parameters:
//   N     data width in bits (N >= 2)
//   SW    shift-amount width (N <= 2**SW)
//
// Ports:
//   clk    in   1    rising-edge clock
//   rst_n  in   1    asynchronous active-low reset
//   start  in   1    request, only honoured in IDLE
//   A      in   N    operand
//   SHAMT  in   SW   shift amount, clamped to N-1 when >= N
//   MODE   in   2    00 SLL, 01 SRL, 10 SRA, 11 ROL (or SLL, see below)
//   Z      out  N    result register, holds between done pulses
//   busy   out  1    high while in SHIFT
//   done   out  1    one-cycle pulse when Z is updated
//
// Build option: define ALU_SHIFT_ROTATE_EN to make MODE=11 a rotate-left.
// Without it, MODE=11 behaves as SLL and no rotate path exists.

module alu_shift_seq #(
    parameter int N  = 16,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [N-1:0]  A,
    input  logic [SW-1:0] SHAMT,
    input  logic [1:0]    MODE,
    output logic [N-1:0]  Z,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // SW+1 bits so that N == 2**SW is still representable in the compare
    localparam logic [SW:0]   N_EXT     = (SW+1)'(N);
    localparam logic [SW-1:0] SHAMT_MAX = SW'(N - 1);

    state_t        state_reg, state_next;
    logic [N-1:0]  work_reg,  work_next;
    logic [SW-1:0] cnt_reg,   cnt_next;
    logic [1:0]    mode_reg,  mode_next;
    logic [N-1:0]  z_reg,     z_next;
    logic          done_reg,  done_next;

    logic [SW-1:0] shamt_clamped;
    logic [N-1:0]  work_shifted;

    assign shamt_clamped = ({1'b0, SHAMT} >= N_EXT) ? SHAMT_MAX : SHAMT;

    // One shift step of the working register according to the latched mode
    always_comb begin
        work_shifted = {work_reg[N-2:0], 1'b0};
        case (mode_reg)
            2'b00:   work_shifted = {work_reg[N-2:0], 1'b0};
            2'b01:   work_shifted = {1'b0, work_reg[N-1:1]};
            2'b10:   work_shifted = {work_reg[N-1], work_reg[N-1:1]};
`ifdef ALU_SHIFT_ROTATE_EN
            default: work_shifted = {work_reg[N-2:0], work_reg[N-1]};
`else
            default: work_shifted = {work_reg[N-2:0], 1'b0};
`endif
        endcase
    end

    always_comb begin
        state_next = state_reg;
        work_next  = work_reg;
        cnt_next   = cnt_reg;
        mode_next  = mode_reg;
        z_next     = z_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    work_next  = A;
                    cnt_next   = shamt_clamped;
                    mode_next  = MODE;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_reg != '0) begin
                    work_next = work_shifted;
                    cnt_next  = cnt_reg - 1'b1;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // done is registered, so it rises together with Z on this edge
                z_next     = work_reg;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            work_reg  <= '0;
            cnt_reg   <= '0;
            mode_reg  <= '0;
            z_reg     <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            work_reg  <= work_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode_next;
            z_reg     <= z_next;
            done_reg  <= done_next;
        end
    end

    assign Z    = z_reg;
    assign done = done_reg;
    assign busy = (state_reg == SHIFT);

endmodule

// File: tb/tb_alu_shift_seq.sv
// Testbench for alu_shift_seq (N=16, SW=4).
// A reference model tracks, per operation, the accept edge, the clamped
// shift amount and the arithmetic result; from these it derives when busy,
// done and Z must change. A negedge process compares the DUT every cycle.
// Directed operations pin the model against hand-computed results.

module tb_alu_shift_seq;

    localparam int N  = 16;
    localparam int SW = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  A;
    logic [SW-1:0] SHAMT;
    logic [1:0]    MODE;
    logic [N-1:0]  Z;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    alu_shift_seq #(.N(N), .SW(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .SHAMT (SHAMT),
        .MODE  (MODE),
        .Z     (Z),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Result of shifting a by the clamped amount in one go
    function automatic logic [N-1:0] ref_shift(input logic [N-1:0] a,
                                               input logic [SW-1:0] sh,
                                               input logic [1:0] m);
        int s;
        s = (int'(sh) >= N) ? N - 1 : int'(sh);
        case (m)
            2'd0:    return a << s;
            2'd1:    return a >> s;
            2'd2:    return N'($signed(a) >>> s);
`ifdef ALU_SHIFT_ROTATE_EN
            default: return (a << s) | (a >> (N - s));
`else
            default: return a << s;
`endif
        endcase
    endfunction

    // ---------------- reference model ----------------
    int           edge_n      = 0;     // index of the last rising edge
    bit           m_active    = 1'b0;  // an operation is in flight
    int           m_acc       = -100;  // edge at which it was accepted
    int           m_s         = 0;     // clamped shift amount
    logic [N-1:0] m_res       = '0;
    logic [N-1:0] m_z         = '0;
    int           m_done_edge = -100;

    // Inputs change only at posedge+2, so values seen at negedge are the ones
    // the next rising edge samples.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_active    = 1'b0;
            m_z         = '0;
            m_done_edge = -100;
            m_acc       = -100;
        end
        chk("busy", 32'(busy), 32'(m_active && (edge_n >= m_acc) && (edge_n <= m_acc + m_s)));
        chk("done", 32'(done), 32'(edge_n == m_done_edge));
        chk("Z", 32'(Z), 32'(m_z));
        if (rst_n) begin
            edge_n++;
            if (!m_active && start) begin
                m_active = 1'b1;
                m_acc    = edge_n;
                m_s      = (int'(SHAMT) >= N) ? N - 1 : int'(SHAMT);
                m_res    = ref_shift(A, SHAMT, MODE);
            end else if (m_active && edge_n == m_acc + m_s + 2) begin
                m_z         = m_res;
                m_done_edge = edge_n;
                m_active    = 1'b0;
            end
        end
    end

    // ---------------- directed operation ----------------
    task automatic do_op(input string name, input logic [N-1:0] a, input logic [SW-1:0] s,
                         input logic [1:0] m, input bit second, input logic [N-1:0] exp_z);
        int lat;
        int busy_cnt;
        @(posedge clk); #2;
        start = 1'b1; A = a; SHAMT = s; MODE = m;
        @(posedge clk); #2;               // accept edge passed
        busy_cnt = busy ? 1 : 0;
        if (second) begin
            start = 1'b1; A = 16'h1234; SHAMT = 4'd2; MODE = 2'b00;
        end else begin
            start = 1'b0; A = N'($urandom); SHAMT = SW'($urandom); MODE = 2'($urandom);
        end
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            A = N'($urandom); SHAMT = SW'($urandom); MODE = 2'($urandom);
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_cnt++;
        end
        chk({name, "_latency"}, 32'(lat), 32'(int'(s) + 2));
        chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(int'(s) + 1));
        chk({name, "_Z"}, 32'(Z), 32'(exp_z));
        chk({name, "_model"}, 32'(m_z), 32'(exp_z));
        $display("op %s: A=%h SHAMT=%0d MODE=%0d -> Z=%h latency=%0d busy=%0d", name, a, s, m, Z, lat, busy_cnt);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] rol_exp;
        rst_n = 1'b0; start = 1'b0; A = '0; SHAMT = '0; MODE = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_Z", 32'(Z), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        rst_n = 1'b1;

        // First start right after reset release
        do_op("first_after_reset", 16'h0001, 4'd4, 2'b00, 1'b0, 16'h0010);

        // Randomised traffic: model checks every cycle
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            start = ($urandom_range(0, 3) == 0);
            A = N'($urandom); SHAMT = SW'($urandom); MODE = 2'($urandom);
        end
        @(posedge clk); #2;
        start = 1'b0;
        repeat (40) @(posedge clk);

        do_op("sll", 16'h0001, 4'd4, 2'b00, 1'b0, 16'h0010);
        do_op("sra", 16'h8000, 4'd15, 2'b10, 1'b0, 16'hFFFF);
        do_op("srl", 16'h8000, 4'd15, 2'b01, 1'b0, 16'h0001);
`ifdef ALU_SHIFT_ROTATE_EN
        rol_exp = 16'h0003;
`else
        rol_exp = 16'h0002;
`endif
        do_op("mode11", 16'h8001, 4'd1, 2'b11, 1'b0, rol_exp);
        do_op("shamt0", 16'hBEEF, 4'd0, 2'b00, 1'b0, 16'hBEEF);
        do_op("second_start", 16'h00F0, 4'd3, 2'b01, 1'b1, 16'h001E);
        repeat (3) @(posedge clk);
        chk("hold_Z", 32'(Z), 32'h001E);

        // Reset in the middle of an operation
        @(posedge clk); #2;
        start = 1'b1; A = 16'h00FF; SHAMT = 4'd8; MODE = 2'b00;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_Z", 32'(Z), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        $display("op abort: reset applied mid-operation, Z=%h busy=%0d done=%0d", Z, busy, done);
        do_op("after_abort", 16'h00FF, 4'd8, 2'b00, 1'b0, 16'hFF00);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
